// File: rtl/uart_pkg.sv
// Shared UART types: frame configuration and the TX/RX state encodings.
package uart_pkg;

   typedef struct packed {
      logic [1:0] data_bits;   // 0 -> 5 bits ... 3 -> 8 bits
      logic       parity_en;
      logic       parity_type; // 0 = even, 1 = odd
      logic       stop_bits;   // 0 -> 1 stop bit, 1 -> 2 stop bits
   } uart_cfg_t;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
   } rx_state_e;

   function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
      case (data_bits)
         2'd0:    data_mask = 8'h1F;
         2'd1:    data_mask = 8'h3F;
         2'd2:    data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Clearable tick generator: one-cycle tick every max(div_i,1) clocks.
module uart_baud_gen #(
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 arst_ni,
   input  logic                 clr_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 tick_o
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] last_q;
   logic [DIV_WIDTH-1:0] last_d;

   // Divider is only resampled on clear or tick so a change lands on a tick boundary.
   assign last_d = (div_i == '0) ? '0 : div_i - 1'b1;
   assign tick_o = !clr_i && (cnt_q == last_q);

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         cnt_q  <= '0;
         last_q <= '0;
      end else if (clr_i || tick_o) begin
         cnt_q  <= '0;
         last_q <= last_d;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_engine.sv
// Single-clock UART TX/RX engine with oversampled clock-enable timing,
// configurable frame format and a one-entry RX holding register.
module uart_engine
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                 clk_i,
   input  logic                 arst_ni,
   input  logic                 enable_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  uart_cfg_t            cfg_i,
   input  logic [7:0]           tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic                 tx_busy_o,
   output logic                 tx_o,
   input  logic                 rx_i,
   output logic [7:0]           rx_data_o,
   output logic                 rx_parity_err_o,
   output logic                 rx_frame_err_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 rx_overrun_o,
   output logic                 rx_break_o
);

   localparam int unsigned OSW = $clog2(OVERSAMPLE);
   typedef logic [OSW-1:0] os_t;
   localparam os_t OS_LAST = os_t'(OVERSAMPLE - 1);
   localparam os_t OS_MID  = os_t'(OVERSAMPLE / 2 - 1);

   // ---------------- TX ----------------
   tx_state_e  tx_state_q, tx_state_d;
   logic [1:0] tx_db_q;
   logic       tx_pen_q, tx_stop_q, tx_par_q, tx_run_q, tx_tick, tx_fire, tx_bit_end;
   logic [7:0] tx_sh_q;
   os_t        tx_os_q;
   logic [2:0] tx_bit_q;

   assign tx_ready_o = enable_i && tx_run_q && (tx_state_q == TX_IDLE);
   assign tx_busy_o  = (tx_state_q != TX_IDLE);
   assign tx_fire    = tx_valid_i && tx_ready_o;
   assign tx_bit_end = tx_tick && (tx_os_q == OS_LAST);

   uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tx_baud (
      .clk_i(clk_i), .arst_ni(arst_ni), .clr_i(tx_fire), .div_i(div_i), .tick_o(tx_tick)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      if (!enable_i) begin
         tx_state_d = TX_IDLE;
      end else begin
         case (tx_state_q)
            TX_IDLE:   if (tx_fire) tx_state_d = TX_START;
            TX_START:  if (tx_bit_end) tx_state_d = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bit_q == ({1'b0, tx_db_q} + 3'd4))
                          tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
            TX_STOP:   if (tx_bit_end && (!tx_stop_q || tx_bit_q[0])) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
         endcase
      end
   end

   always_comb begin
      case (tx_state_q)
         TX_START:  tx_o = 1'b0;
         TX_DATA:   tx_o = tx_sh_q[0];
         TX_PARITY: tx_o = tx_par_q;
         default:   tx_o = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         tx_state_q <= TX_IDLE;
         tx_run_q   <= 1'b0;
         tx_db_q    <= '0;
         tx_pen_q   <= 1'b0;
         tx_stop_q  <= 1'b0;
         tx_par_q   <= 1'b0;
         tx_sh_q    <= '0;
         tx_os_q    <= '0;
         tx_bit_q   <= '0;
      end else begin
         tx_run_q   <= 1'b1;
         tx_state_q <= tx_state_d;
         if (tx_fire) begin
            tx_db_q   <= cfg_i.data_bits;
            tx_pen_q  <= cfg_i.parity_en;
            tx_stop_q <= cfg_i.stop_bits;
            tx_par_q  <= ^(tx_data_i & data_mask(cfg_i.data_bits)) ^ cfg_i.parity_type;
            tx_sh_q   <= tx_data_i;
            tx_os_q   <= '0;
            tx_bit_q  <= '0;
         end else if (tx_tick) begin
            tx_os_q <= tx_os_q + 1'b1;
            if (tx_bit_end) begin
               if (tx_state_q == TX_DATA) tx_sh_q <= tx_sh_q >> 1;
               tx_bit_q <= (tx_state_d == tx_state_q) ? tx_bit_q + 3'd1 : 3'd0;
            end
         end
      end
   end

   // ---------------- RX ----------------
   rx_state_e  rx_state_q, rx_state_d;
   uart_cfg_t  rx_cfg_q;
   logic       rx_meta_q, rx_sync_q, rx_prev_q, rx_par_q, rx_tick, rx_fall, rx_sample;
   logic       rx_done, rx_load, rx_par_bad, rx_brk;
   logic [7:0] rx_sh_q;
   os_t        rx_os_q;
   logic [2:0] rx_bit_q;

   assign rx_fall   = enable_i && rx_prev_q && !rx_sync_q && (rx_state_q == RX_IDLE);
   assign rx_sample = rx_tick && (rx_os_q == ((rx_state_q == RX_START) ? OS_MID : OS_LAST));
   assign rx_done   = (rx_state_q == RX_STOP) && rx_sample;
   assign rx_load   = rx_done && (!rx_valid_o || rx_ready_i);
   assign rx_par_bad = rx_cfg_q.parity_en && ((^rx_sh_q ^ rx_cfg_q.parity_type) != rx_par_q);
   assign rx_brk    = (rx_sh_q == '0) && !(rx_cfg_q.parity_en && rx_par_q) && !rx_sync_q;

   uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_rx_baud (
      .clk_i(clk_i), .arst_ni(arst_ni), .clr_i(rx_fall), .div_i(div_i), .tick_o(rx_tick)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      if (!enable_i) begin
         rx_state_d = RX_IDLE;
      end else begin
         case (rx_state_q)
            RX_IDLE:      if (rx_fall) rx_state_d = RX_START;
            RX_START:     if (rx_sample) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_sample && rx_bit_q == ({1'b0, rx_cfg_q.data_bits} + 3'd4))
                             rx_state_d = rx_cfg_q.parity_en ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_sample) rx_state_d = RX_STOP;
            RX_STOP:      if (rx_sample) rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync_q) rx_state_d = RX_IDLE;
            default:      rx_state_d = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cfg_q   <= '0;
         rx_sh_q    <= '0;
         rx_par_q   <= 1'b0;
         rx_os_q    <= '0;
         rx_bit_q   <= '0;
      end else begin
         rx_meta_q  <= rx_i;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         if (rx_fall) begin
            rx_cfg_q <= cfg_i;
            rx_sh_q  <= '0;
            rx_par_q <= 1'b0;
            rx_os_q  <= '0;
            rx_bit_q <= '0;
         end else if (rx_tick) begin
            rx_os_q <= rx_sample ? os_t'(0) : rx_os_q + 1'b1;
            if (rx_sample && rx_state_q == RX_DATA) begin
               rx_sh_q[rx_bit_q] <= rx_sync_q;
               rx_bit_q <= (rx_state_d == rx_state_q) ? rx_bit_q + 3'd1 : 3'd0;
            end
            if (rx_sample && rx_state_q == RX_PARITY) rx_par_q <= rx_sync_q;
         end
      end
   end

   // Holding register: a completion while full and unpopped drops the new byte.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         rx_data_o       <= '0;
         rx_parity_err_o <= 1'b0;
         rx_frame_err_o  <= 1'b0;
         rx_valid_o      <= 1'b0;
         rx_overrun_o    <= 1'b0;
         rx_break_o      <= 1'b0;
      end else begin
         rx_overrun_o <= rx_done && !rx_load;
         rx_break_o   <= rx_done && rx_brk;
         if (rx_load) begin
            rx_data_o       <= rx_sh_q;
            rx_parity_err_o <= rx_par_bad;
            rx_frame_err_o  <= !rx_sync_q;
            rx_valid_o      <= 1'b1;
         end else if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_engine.sv
// Directed self-checking bench for uart_engine (OVERSAMPLE=16, div_i=1 -> 16-cycle bits).
module tb_uart_engine;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        arst_ni = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] div = 16'd1;
   uart_cfg_t   cfg = '0;
   logic [7:0]  tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready, tx_busy, tx_line;
   logic        rx_drv = 1'b1;
   logic        loop = 1'b0;
   logic        rx_line;
   logic [7:0]  rx_data;
   logic        rx_perr, rx_ferr, rx_valid, rx_ovr, rx_brk;
   logic        rx_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int ovr_cnt = 0, brk_cnt = 0, vld_cnt = 0;
   logic vld_d = 1'b0;

   assign rx_line = loop ? tx_line : rx_drv;

   uart_engine #(.OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
      .clk_i(clk), .arst_ni(arst_ni), .enable_i(enable), .div_i(div), .cfg_i(cfg),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_busy_o(tx_busy),
      .tx_o(tx_line), .rx_i(rx_line), .rx_data_o(rx_data), .rx_parity_err_o(rx_perr),
      .rx_frame_err_o(rx_ferr), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
      .rx_overrun_o(rx_ovr), .rx_break_o(rx_brk)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_ovr) ovr_cnt++;
      if (rx_brk) brk_cnt++;
      if (rx_valid && !vld_d) vld_cnt++;
      vld_d = rx_valid;
   end

   task automatic clr_mon();
      @(posedge clk);
      ovr_cnt = 0; brk_cnt = 0; vld_cnt = 0;
   endtask

   task automatic pop();
      @(negedge clk); rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Drives one serial frame on rx_drv; pulses rx_ready for one cycle at frame cycle pop_at.
   task automatic drive_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pbit,
                              input bit stopv, input int nstop, input int pop_at);
      bit bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
      if (pen) bits.push_back(pbit);
      for (int i = 0; i < nstop; i++) bits.push_back(stopv);
      for (int b = 0; b < bits.size(); b++) begin
         for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rx_drv = bits[b];
            if (b * 16 + c == pop_at) rx_ready = 1'b1;
            else rx_ready = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      arst_ni = 1'b0;
      idle(3);
      if (tx_line !== 1'b1) begin $display("FAIL reset_tx_o: got %b want 1", tx_line); n_fail++; end
      n_checks++;
      if (tx_ready !== 1'b0) begin $display("FAIL reset_tx_ready: got %b want 0", tx_ready); n_fail++; end
      n_checks++;
      if (tx_busy !== 1'b0) begin $display("FAIL reset_tx_busy: got %b want 0", tx_busy); n_fail++; end
      n_checks++;
      if (rx_valid !== 1'b0) begin $display("FAIL reset_rx_valid: got %b want 0", rx_valid); n_fail++; end
      n_checks++;
      if ({rx_data, rx_perr, rx_ferr, rx_ovr, rx_brk} !== 12'h000) begin
         $display("FAIL reset_rx_outs: got %h want 000", {rx_data, rx_perr, rx_ferr, rx_ovr, rx_brk}); n_fail++;
      end
      n_checks++;
      arst_ni = 1'b1;
      @(negedge clk);
      if (tx_ready !== 1'b1) begin $display("FAIL release_tx_ready: got %b want 1", tx_ready); n_fail++; end
      n_checks++;
   endtask

   task automatic test_tx_8n1();
      logic [9:0] fb;
      fb = {1'b1, 8'hA5, 1'b0};
      cfg = '{data_bits: 2'd3, parity_en: 1'b0, parity_type: 1'b0, stop_bits: 1'b0};
      @(negedge clk); tx_data = 8'hA5; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
      for (int i = 0; i <= 160; i++) begin
         if (i > 0) @(negedge clk);
         if (tx_line !== ((i < 160) ? fb[i/16] : 1'b1)) begin
            $display("FAIL tx8n1_bit cycle %0d: got %b want %b", i, tx_line, (i < 160) ? fb[i/16] : 1'b1); n_fail++;
         end
         n_checks++;
         if (tx_busy !== (i < 160)) begin $display("FAIL tx8n1_busy cycle %0d: got %b", i, tx_busy); n_fail++; end
         n_checks++;
         if (tx_ready !== (i >= 160)) begin $display("FAIL tx8n1_ready cycle %0d: got %b", i, tx_ready); n_fail++; end
         n_checks++;
      end
   endtask

   task automatic test_loopback_7e2();
      int lat;
      lat = -1;
      clr_mon();
      loop = 1'b1;
      cfg = '{data_bits: 2'd2, parity_en: 1'b1, parity_type: 1'b0, stop_bits: 1'b1};
      @(negedge clk); tx_data = 8'h41; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 8 * 16 + 8) begin
            if (tx_line !== 1'b0) begin $display("FAIL lb_parity_bit: got %b want 0", tx_line); n_fail++; end
            n_checks++;
         end
         if (rx_valid && lat < 0) lat = i;
         if (i >= 180) break;
      end
      if (lat !== 155) begin $display("FAIL lb_latency: got %0d want 155", lat); n_fail++; end
      n_checks++;
      if (rx_data !== 8'h41) begin $display("FAIL lb_data: got %h want 41", rx_data); n_fail++; end
      n_checks++;
      if ({rx_perr, rx_ferr, brk_cnt != 0, ovr_cnt != 0} !== 4'b0000) begin
         $display("FAIL lb_flags: got %b want 0000", {rx_perr, rx_ferr, brk_cnt != 0, ovr_cnt != 0}); n_fail++;
      end
      n_checks++;
      if (tx_ready !== 1'b1) begin $display("FAIL lb_tx_done: got %b want 1", tx_ready); n_fail++; end
      n_checks++;
      loop = 1'b0;
      pop();
      if (rx_valid !== 1'b0) begin $display("FAIL lb_pop: got %b want 0", rx_valid); n_fail++; end
      n_checks++;
   endtask

   task automatic test_frame_err();
      clr_mon();
      cfg = '{data_bits: 2'd3, parity_en: 1'b0, parity_type: 1'b0, stop_bits: 1'b0};
      drive_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, -1);
      idle(40);
      rx_drv = 1'b1;
      idle(20);
      if (vld_cnt !== 1) begin $display("FAIL ferr_count: got %0d want 1", vld_cnt); n_fail++; end
      n_checks++;
      if (rx_data !== 8'h3C) begin $display("FAIL ferr_data: got %h want 3c", rx_data); n_fail++; end
      n_checks++;
      if ({rx_ferr, rx_perr} !== 2'b10) begin $display("FAIL ferr_flags: got %b want 10", {rx_ferr, rx_perr}); n_fail++; end
      n_checks++;
      if (brk_cnt !== 0) begin $display("FAIL ferr_no_break: got %0d want 0", brk_cnt); n_fail++; end
      n_checks++;
      pop();
      drive_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1, -1);
      idle(4);
      if ({rx_valid, rx_data, rx_ferr} !== {1'b1, 8'h5A, 1'b0}) begin
         $display("FAIL ferr_recover: got %b/%h/%b want 1/5a/0", rx_valid, rx_data, rx_ferr); n_fail++;
      end
      n_checks++;
      pop();
   endtask

   task automatic test_break();
      clr_mon();
      rx_drv = 1'b0;
      idle(320);
      if ({vld_cnt, brk_cnt} !== {32'd1, 32'd1}) begin
         $display("FAIL break_pulses: got valid %0d break %0d want 1 1", vld_cnt, brk_cnt); n_fail++;
      end
      n_checks++;
      if ({rx_data, rx_ferr, rx_perr} !== {8'h00, 1'b1, 1'b0}) begin
         $display("FAIL break_byte: got %h/%b/%b want 00/1/0", rx_data, rx_ferr, rx_perr); n_fail++;
      end
      n_checks++;
      rx_drv = 1'b1;
      idle(200);
      if ({vld_cnt, brk_cnt} !== {32'd1, 32'd1}) begin
         $display("FAIL break_release: got valid %0d break %0d want 1 1", vld_cnt, brk_cnt); n_fail++;
      end
      n_checks++;
      pop();
   endtask

   task automatic test_overrun();
      clr_mon();
      drive_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1, -1);
      drive_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1, -1);
      idle(4);
      if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin
         $display("FAIL ovr_keep: got %b/%h want 1/11", rx_valid, rx_data); n_fail++;
      end
      n_checks++;
      if (ovr_cnt !== 1) begin $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt); n_fail++; end
      n_checks++;
      pop();
      clr_mon();
      drive_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1, -1);
      drive_frame(8'h44, 8, 1'b0, 1'b0, 1'b1, 1, 154);
      idle(4);
      if ({rx_valid, rx_data} !== {1'b1, 8'h44}) begin
         $display("FAIL ovr_pop_same_cycle: got %b/%h want 1/44", rx_valid, rx_data); n_fail++;
      end
      n_checks++;
      if (ovr_cnt !== 0) begin $display("FAIL ovr_none: got %0d want 0", ovr_cnt); n_fail++; end
      n_checks++;
      pop();
   endtask

   task automatic test_glitch();
      clr_mon();
      rx_drv = 1'b0;
      idle(3);
      rx_drv = 1'b1;
      idle(60);
      if ({vld_cnt, brk_cnt} !== {32'd0, 32'd0}) begin
         $display("FAIL glitch: got valid %0d break %0d want 0 0", vld_cnt, brk_cnt); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_back_to_back();
      logic [9:0] fb2;
      fb2 = {1'b1, 8'hC3, 1'b0};
      cfg = '{data_bits: 2'd3, parity_en: 1'b0, parity_type: 1'b0, stop_bits: 1'b0};
      @(negedge clk); tx_data = 8'h5A; tx_valid = 1'b1;
      for (int i = 0; i <= 161 + 160; i++) begin
         @(negedge clk);
         if (i == 159) begin
            if (tx_ready !== 1'b0) begin $display("FAIL b2b_ready_early: got %b want 0", tx_ready); n_fail++; end
            n_checks++;
         end
         if (i == 160) begin
            if (tx_ready !== 1'b1) begin $display("FAIL b2b_ready: got %b want 1", tx_ready); n_fail++; end
            n_checks++;
            tx_data = 8'hC3;
         end
         if (i == 161) tx_valid = 1'b0;
         if (i >= 161 && ((i - 161) % 16) == 8) begin
            if (tx_line !== fb2[(i - 161) / 16]) begin
               $display("FAIL b2b_bit %0d: got %b want %b", (i - 161) / 16, tx_line, fb2[(i - 161) / 16]); n_fail++;
            end
            n_checks++;
         end
      end
   endtask

   task automatic test_enable();
      cfg = '{data_bits: 2'd3, parity_en: 1'b0, parity_type: 1'b0, stop_bits: 1'b0};
      @(negedge clk); tx_data = 8'h00; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
      idle(40);
      if (tx_line !== 1'b0) begin $display("FAIL en_mid_frame: got %b want 0", tx_line); n_fail++; end
      n_checks++;
      enable = 1'b0;
      @(negedge clk);
      if ({tx_line, tx_busy, tx_ready} !== 3'b100) begin
         $display("FAIL en_low: got %b want 100", {tx_line, tx_busy, tx_ready}); n_fail++;
      end
      n_checks++;
      enable = 1'b1;
      @(negedge clk);
      if (tx_ready !== 1'b1) begin $display("FAIL en_high: got %b want 1", tx_ready); n_fail++; end
      n_checks++;
   endtask

   task automatic test_reset_mid_tx();
      clr_mon();
      loop = 1'b1;
      @(negedge clk); tx_data = 8'h00; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
      idle(50);
      if (tx_line !== 1'b0) begin $display("FAIL rst_pre: got %b want 0", tx_line); n_fail++; end
      n_checks++;
      #2 arst_ni = 1'b0;
      #1;
      if ({tx_line, tx_busy, tx_ready, rx_valid} !== 4'b1000) begin
         $display("FAIL rst_mid_tx: got %b want 1000", {tx_line, tx_busy, tx_ready, rx_valid}); n_fail++;
      end
      n_checks++;
      idle(3);
      arst_ni = 1'b1;
      idle(200);
      if ({vld_cnt, rx_valid, tx_line} !== {32'd0, 1'b0, 1'b1}) begin
         $display("FAIL rst_no_byte: got valid %0d/%b tx %b want 0/0/1", vld_cnt, rx_valid, tx_line); n_fail++;
      end
      n_checks++;
      loop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tx_8n1();
      test_loopback_7e2();
      test_frame_err();
      test_break();
      test_overrun();
      test_glitch();
      test_back_to_back();
      test_enable();
      test_reset_mid_tx();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
